// File: rtl/data_mem_stall_unit_pkg.sv
// Shared definitions for the data-memory stall unit.
// Holds the FSM state encoding, the bus data width and the default geometry
// (word-address width and access latency) used by the top and the RAM array.
package dmem_pkg;

  localparam int DATA_W      = 32;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_stall_unit_if.sv
// Core <-> data-memory bus.
//   data_adr  : byte address from the core
//   data_wr   : write data from the core
//   mem_write : write request (level)
//   mem_read  : read request (level)
//   data_rd   : registered read data back to the core
//   stall     : freeze request to the core while an access is in flight
// master = core side, slave = memory side.
interface data_mem_stall_unit_if;
  import dmem_pkg::*;

  logic [DATA_W-1:0] data_adr;
  logic [DATA_W-1:0] data_wr;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] data_rd;
  logic              stall;

  modport master (
    output data_adr, data_wr, mem_write, mem_read,
    input  data_rd, stall
  );

  modport slave (
    input  data_adr, data_wr, mem_write, mem_read,
    output data_rd, stall
  );

endinterface

// File: rtl/data_mem_stall_unit_array.sv
// data_mem_array: synchronous single-port word RAM.
//   clk, rst : clock and synchronous active-high reset (read register only)
//   we       : write enable, stores wdata at addr on the rising edge
//   re       : read enable, loads rdata from addr on the rising edge
//   addr     : word address
//   wdata    : write data
//   rdata    : registered read data; holds between reads, cleared by rst
// RAM contents are never reset.
module data_mem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_stall_unit.sv
// data_mem_stall_unit: data-memory stage behind the core's MEM stage.
//   clk : single rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of the core bus (address, write data, read/write
//         strobes in; registered read data and stall out)
// An accepted request stalls the core for exactly LATENCY cycles; the RAM
// access happens on the edge that enters DONE, and DONE ignores the bus so
// the still-present request is not accepted twice.
module data_mem_stall_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_stall_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SINGLE   = (LATENCY == 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;

  logic                req;
  logic                fire;
  logic                fire_wr;
  logic [ADDR_W-1:0]   fire_adr;
  logic [DATA_W-1:0]   fire_wdata;
  logic                ram_we;
  logic                ram_re;
  logic                stall;

  // Byte-lane and above-depth address bits are deliberately ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.data_adr[DATA_W-1:ADDR_W+2], bus.data_adr[1:0]};

  assign req = bus.mem_read | bus.mem_write;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    fire       = 1'b0;
    fire_wr    = is_wr_q;
    fire_adr   = adr_q;
    fire_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d   = bus.data_adr[ADDR_W+1:2];
          wdata_d = bus.data_wr;
          is_wr_d = bus.mem_write;  // write wins when both strobes are set
          cnt_d   = CNT_LOAD;
          if (SINGLE) begin
            // No WAIT state: the access happens on this very edge, so use
            // the live bus values rather than the (not yet loaded) latches.
            state_d    = DONE;
            fire       = 1'b1;
            fire_wr    = is_wr_d;
            fire_adr   = adr_d;
            fire_wdata = wdata_d;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          fire    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset on the would-be DONE edge discards the access.
  assign ram_we = fire &  fire_wr & ~rst;
  assign ram_re = fire & ~fire_wr & ~rst;

  // Only req reaches stall combinationally, and only in IDLE.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = req;
      WAIT:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    adr_q   <= adr_d;
    wdata_q <= wdata_d;
    is_wr_q <= is_wr_d;
  end

  data_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (fire_adr),
    .wdata (fire_wdata),
    .rdata (bus.data_rd)
  );

  assign bus.stall = stall;

endmodule

// File: tb/tb_data_mem_stall_unit.sv
// Bench for data_mem_stall_unit: one instance with LATENCY=3, one with
// LATENCY=1, both ADDR_W=10. Accesses come from vector tables; each record
// carries the data_rd value expected in that access's DONE cycle, queued on
// drive and popped when the DONE cycle is sampled.
module tb_data_mem_stall_unit;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  data_mem_stall_unit_if bus_a ();
  data_mem_stall_unit_if bus_b ();

  data_mem_stall_unit #(.ADDR_W(10), .LATENCY(3), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  data_mem_stall_unit #(.ADDR_W(10), .LATENCY(1), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        ta [9];
  vec_t        tb [8];
  logic [31:0] sb_q [$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit which, input bit wr, input bit rd,
                       input logic [31:0] adr, input logic [31:0] data);
    if (!which) begin
      bus_a.mem_write = wr;
      bus_a.mem_read  = rd;
      bus_a.data_adr  = adr;
      bus_a.data_wr   = data;
    end else begin
      bus_b.mem_write = wr;
      bus_b.mem_read  = rd;
      bus_b.data_adr  = adr;
      bus_b.data_wr   = data;
    end
  endtask

  function automatic logic [31:0] get_stall(input bit which);
    return which ? {31'd0, bus_b.stall} : {31'd0, bus_a.stall};
  endfunction

  function automatic logic [31:0] get_rd(input bit which);
    return which ? bus_b.data_rd : bus_a.data_rd;
  endfunction

  // One access, request held by the core until the end of DONE.
  task automatic access(input bit which, input int lat, input vec_t v, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    drive(which, v.wr, v.rd, v.adr, v.data);
    sb_q.push_back(v.exp_rd);
    #1 check({tag, " stall accept"}, get_stall(which), 32'd1);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      #1 check($sformatf("%s stall wait%0d", tag, i), get_stall(which), 32'd1);
    end
    @(negedge clk);
    #1 check({tag, " stall done"}, get_stall(which), 32'd0);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, " data_rd"}, get_rd(which), exp);
    end
  endtask

  initial begin
    ta[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    ta[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
    ta[2] = '{1'b1, 1'b0, 32'h0000_1004, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    ta[3] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'hCAFE_F00D};
    ta[4] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'hCAFE_F00D};
    ta[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D};
    ta[6] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678};
    ta[7] = '{1'b0, 1'b1, 32'hFFFF_F020, 32'h0000_0000, 32'h1234_5678};
    ta[8] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_5555, 32'h1234_5678};

    tb[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111, 32'h0000_0000};
    tb[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000, 32'h1111_1111};
    tb[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h2222_2222, 32'h1111_1111};
    tb[3] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0000_0000, 32'h2222_2222};
    tb[4] = '{1'b1, 1'b0, 32'h0000_0100, 32'h3333_3333, 32'h2222_2222};
    tb[5] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000, 32'h3333_3333};
    tb[6] = '{1'b1, 1'b1, 32'h0000_0104, 32'h4444_4444, 32'h3333_3333};
    tb[7] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0000_0000, 32'h4444_4444};

    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Idle after reset: no stall, data_rd cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle%0d stall a", i), get_stall(1'b0), 32'd0);
      check($sformatf("idle%0d rd a", i),    get_rd(1'b0),    32'd0);
      check($sformatf("idle%0d stall b", i), get_stall(1'b1), 32'd0);
      check($sformatf("idle%0d rd b", i),    get_rd(1'b1),    32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      access(1'b0, 3, ta[i], $sformatf("lat3 v%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      access(1'b1, 1, tb[i], $sformatf("lat1 v%0d", i));
    end

    // Reset during WAIT of a write: the write must be discarded.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_AAAA);
    #1 check("rstwait stall accept", get_stall(1'b0), 32'd1);
    @(negedge clk);
    #1 check("rstwait stall wait", get_stall(1'b0), 32'd1);
    rst_a = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("rstwait stall after rst", get_stall(1'b0), 32'd0);
    check("rstwait rd after rst",    get_rd(1'b0),    32'd0);
    rst_a = 1'b0;
    @(negedge clk);
    #1 check("rstwait idle stall", get_stall(1'b0), 32'd0);
    access(1'b0, 3, '{1'b0, 1'b1, 32'h0000_0030, 32'h0, 32'h0000_5555}, "rstwait readback");

    // Request dropped after DONE: unit returns to idle without re-accepting.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("final idle stall a", get_stall(1'b0), 32'd0);
    check("final idle stall b", get_stall(1'b1), 32'd0);
    check("final rd a", get_rd(1'b0), 32'h0000_5555);
    check("final rd b", get_rd(1'b1), 32'h4444_4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
